// File: rtl/tpu_pkg.sv
// tpu_pkg: host-controller FSM states, buffer widths, default index width and the ceil(x/4) sizing helper
package tpu_pkg;
    localparam int IDX_W = 16;
    localparam int IN_W  = 32;
    localparam int OUT_W = 128;
    typedef enum logic [3:0] {
        IDLE, LOAD_A, LOAD_B, START, WAIT_HI, WAIT_LO, DRAIN_RD, DRAIN_CAP, DRAIN_OUT, FINISH
    } state_e;
    function automatic logic [7:0] ceil4(input logic [7:0] x);
        return 8'((9'(x) + 9'd3) >> 2);
    endfunction
endpackage

// File: rtl/tpu_c_drain.sv
// tpu_c_drain: C readback (address, capture, present) with row counter; ports: state/row_clr from host FSM, n_c rows, C read port, m_valid/m_ready/m_data stream, last-row flag
module tpu_c_drain
    import tpu_pkg::*;
#(
    parameter int IDX_W = tpu_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  state_e           state,
    input  logic             row_clr,
    input  logic [15:0]      n_c,
    input  logic [OUT_W-1:0] C_data_out,
    input  logic             m_ready,
    output logic [IDX_W-1:0] C_index,
    output logic             m_valid,
    output logic [OUT_W-1:0] m_data,
    output logic             last
);
    logic [15:0] row;
    assign C_index = IDX_W'(row);
    assign m_valid = state == DRAIN_OUT;
    assign last    = row == n_c - 16'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row    <= '0;
            m_data <= '0;
        end else begin
            if (row_clr)
                row <= '0;
            else if (m_valid && m_ready && !last)
                row <= row + 16'd1;
            if (state == DRAIN_CAP)
                m_data <= C_data_out;
        end
    end
endmodule

// File: rtl/tpu_host_ctrl.sv
// tpu_host_ctrl: TPU job sequencer; ports: cfg job handshake + dims, s_* operand stream, A/B buffer write ports, C read port, tpu start/dims/busy, m_* result stream, done/cfg_err
module tpu_host_ctrl
    import tpu_pkg::*;
#(
    parameter int IDX_W = tpu_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [7:0]       cfg_K,
    input  logic [7:0]       cfg_M,
    input  logic [7:0]       cfg_N,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    output logic             A_wr_en,
    output logic [IDX_W-1:0] A_index,
    output logic [IN_W-1:0]  A_data_in,
    output logic             B_wr_en,
    output logic [IDX_W-1:0] B_index,
    output logic [IN_W-1:0]  B_data_in,
    output logic [IDX_W-1:0] C_index,
    input  logic [OUT_W-1:0] C_data_out,
    output logic             tpu_in_valid,
    output logic [7:0]       tpu_K,
    output logic [7:0]       tpu_M,
    output logic [7:0]       tpu_N,
    input  logic             tpu_busy,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             done,
    output logic             cfg_err
);
    state_e      state;
    logic [15:0] cnt, n_a, n_b, n_c;
    logic        zero_q, in_a, in_b, beat, fin_beat, last;
    assign in_a         = state == LOAD_A && !zero_q;
    assign in_b         = state == LOAD_B;
    assign s_ready      = in_a || in_b;
    assign beat         = s_valid && s_ready;
    assign fin_beat     = cnt == (in_a ? n_a : n_b) - 16'd1;
    assign cfg_ready    = state == IDLE;
    assign A_wr_en      = beat && in_a;
    assign B_wr_en      = beat && in_b;
    assign A_index      = in_a ? IDX_W'(cnt) : '0;
    assign B_index      = in_b ? IDX_W'(cnt) : '0;
    assign A_data_in    = A_wr_en ? s_data : '0;
    assign B_data_in    = B_wr_en ? s_data : '0;
    assign tpu_in_valid = state == START;
    assign done         = state == FINISH;
    assign cfg_err      = done && zero_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            n_a    <= '0;
            n_b    <= '0;
            n_c    <= '0;
            zero_q <= 1'b0;
            tpu_K  <= '0;
            tpu_M  <= '0;
            tpu_N  <= '0;
        end else begin
            case (state)
                IDLE: if (cfg_valid) begin
                    tpu_K  <= cfg_K;
                    tpu_M  <= cfg_M;
                    tpu_N  <= cfg_N;
                    n_a    <= 16'(cfg_K) * 16'(ceil4(cfg_M));
                    n_b    <= 16'(cfg_K) * 16'(ceil4(cfg_N));
                    n_c    <= 16'(cfg_M) * 16'(ceil4(cfg_N));
                    zero_q <= cfg_K == 8'd0 || cfg_M == 8'd0 || cfg_N == 8'd0;
                    cnt    <= '0;
                    state  <= LOAD_A;
                end
                LOAD_A: if (zero_q)
                    state <= FINISH;
                else if (beat) begin
                    cnt   <= fin_beat ? '0 : cnt + 16'd1;
                    state <= fin_beat ? LOAD_B : LOAD_A;
                end
                LOAD_B: if (beat) begin
                    cnt   <= fin_beat ? '0 : cnt + 16'd1;
                    state <= fin_beat ? START : LOAD_B;
                end
                START:     state <= WAIT_HI;
                WAIT_HI:   if (tpu_busy) state <= WAIT_LO;
                WAIT_LO:   if (!tpu_busy) state <= DRAIN_RD;
                DRAIN_RD:  state <= DRAIN_CAP;
                DRAIN_CAP: state <= DRAIN_OUT;
                DRAIN_OUT: if (m_ready) state <= last ? FINISH : DRAIN_RD;
                FINISH:    state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end
    tpu_c_drain #(.IDX_W(IDX_W)) u_drain (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .row_clr   (state == WAIT_LO && !tpu_busy),
        .n_c       (n_c),
        .C_data_out(C_data_out),
        .m_ready   (m_ready),
        .C_index   (C_index),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .last      (last)
    );
endmodule

// File: tb/tb_tpu_host_ctrl.sv
// tb_tpu_host_ctrl: table-driven job bench with result scoreboard, C buffer model and TPU busy model
module tb_tpu_host_ctrl;
    logic         clk = 0, rst_n = 0;
    logic         cfg_valid = 0, cfg_ready;
    logic [7:0]   cfg_K = 0, cfg_M = 0, cfg_N = 0;
    logic         s_valid = 0, s_ready;
    logic [31:0]  s_data = 0;
    logic         A_wr_en, B_wr_en;
    logic [15:0]  A_index, B_index, C_index;
    logic [31:0]  A_data_in, B_data_in;
    logic [127:0] C_data_out = '0;
    logic         tpu_in_valid, tpu_busy = 0;
    logic [7:0]   tpu_K, tpu_M, tpu_N;
    logic         m_valid, m_ready = 0;
    logic [127:0] m_data;
    logic         done, cfg_err;

    tpu_host_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_K(cfg_K), .cfg_M(cfg_M), .cfg_N(cfg_N),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .A_wr_en(A_wr_en), .A_index(A_index), .A_data_in(A_data_in),
        .B_wr_en(B_wr_en), .B_index(B_index), .B_data_in(B_data_in),
        .C_index(C_index), .C_data_out(C_data_out),
        .tpu_in_valid(tpu_in_valid), .tpu_K(tpu_K), .tpu_M(tpu_M), .tpu_N(tpu_N), .tpu_busy(tpu_busy),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] k, m, n;
        bit         tog;
        int         hold, pre, blen, na, nb, nc;
        bit         err;
    } job_t;

    job_t         jobs[7];
    logic [127:0] exp_q[$];
    int           passed = 0, total = 0, cyc = 0, jobid = 0;
    int           a_cnt, b_cnt, n_start, n_done, n_rows, excl_err, dims_err, cur_na;
    int           a_last, b_last, c_last, acc_cyc, done_cyc, start_cyc, mv_cyc;
    logic [7:0]   cur_k, cur_m, cur_n;
    bit           done_seen, err_at_done, prev_mv, prev_hs;
    logic [127:0] prev_md;

    function automatic logic [31:0] word(input int j, input int i);
        return {8'(j), 8'h5A, 16'(i)};
    endfunction

    function automatic logic [127:0] c_word(input int j, input int r);
        return {8'(j), 24'hC0FFEE, 16'(r), 16'hBEEF, 32'(r) * 32'h9E3779B1, 32'hA5A50000 | 32'(r)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        C_data_out <= c_word(jobid, int'(C_index));
    end

    always @(negedge clk) if (rst_n) begin
        if (cfg_valid && cfg_ready) acc_cyc = cyc;
        if (int'(A_wr_en) + int'(B_wr_en) + int'(tpu_in_valid) + int'(done) > 1) excl_err++;
        if (!cfg_ready && (tpu_K !== cur_k || tpu_M !== cur_m || tpu_N !== cur_n)) dims_err++;
        if (s_valid && s_ready) chk("hs_write", 128'(A_wr_en || B_wr_en), 128'(1));
        if (A_wr_en) begin
            chk("a_hs", 128'(s_valid && s_ready), 128'(1));
            chk("a_idx", 128'(A_index), 128'(a_cnt));
            chk("a_data", 128'(A_data_in), 128'(word(jobid, a_cnt)));
            a_last = int'(A_index);
            a_cnt++;
        end
        if (B_wr_en) begin
            chk("b_hs", 128'(s_valid && s_ready), 128'(1));
            chk("b_idx", 128'(B_index), 128'(b_cnt));
            chk("b_data", 128'(B_data_in), 128'(word(jobid, cur_na + b_cnt)));
            b_last = int'(B_index);
            b_cnt++;
        end
        if (tpu_in_valid) begin
            n_start++;
            start_cyc = cyc;
        end
        if (m_valid) begin
            if (mv_cyc < 0) mv_cyc = cyc;
            if (prev_mv && !prev_hs) chk("m_stable", m_data, prev_md);
            if (m_ready) begin
                if (exp_q.size() == 0) chk("m_extra_row", 128'(1), 128'(0));
                else chk("m_data", m_data, exp_q.pop_front());
                c_last = int'(C_index);
                n_rows++;
            end
        end
        prev_mv = m_valid;
        prev_hs = m_valid && m_ready;
        prev_md = m_data;
        if (done) begin
            n_done++;
            done_seen = 1;
            done_cyc = cyc;
            err_at_done = cfg_err;
        end
    end

    task automatic clear_job(input int na, input logic [7:0] k, input logic [7:0] m, input logic [7:0] n);
        jobid++;
        a_cnt = 0; b_cnt = 0; n_start = 0; n_done = 0; n_rows = 0; excl_err = 0; dims_err = 0;
        a_last = -1; b_last = -1; c_last = -1; mv_cyc = -1; done_seen = 0;
        cur_na = na; cur_k = k; cur_m = m; cur_n = n;
        exp_q.delete();
    endtask

    task automatic stream(input int tot, input bit tog);
        int i = 0, t = 0;
        bit hs;
        while (i < tot && t < 2000) begin
            s_valid = tog ? (t % 2 == 0) : 1'b1;
            s_data = word(jobid, i);
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            if (hs) i++;
            t++;
        end
        s_valid = 0;
        chk("stream_done", 128'(i), 128'(tot));
    endtask

    task automatic check_idle_outputs();
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        chk("rst_a_wr", 128'({A_wr_en, B_wr_en, A_index, B_index}), 128'(0));
        chk("rst_tpu", 128'({tpu_in_valid, tpu_K, tpu_M, tpu_N}), 128'(0));
        chk("rst_m_valid", 128'({m_valid, done, cfg_err}), 128'(0));
        chk("rst_c_index", 128'(C_index), 128'(0));
        chk("rst_m_data", m_data, 128'(0));
    endtask

    task automatic start_job(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n);
        chk("cfg_ready", 128'(cfg_ready), 128'(1));
        cfg_K = k; cfg_M = m; cfg_N = n; cfg_valid = 1;
        @(posedge clk); #1 cfg_valid = 0;
    endtask

    task automatic run_job(input job_t j);
        int t, w;
        bit found;
        clear_job(j.na, j.k, j.m, j.n);
        for (int r = 0; r < j.nc; r++) exp_q.push_back(c_word(jobid, r));
        start_job(j.k, j.m, j.n);
        if (!j.err) begin
            stream(j.na + j.nb, j.tog);
            found = 0; t = 0;
            while (!found && t < 50) begin
                @(negedge clk);
                found = tpu_in_valid;
                t++;
            end
            chk("start_seen", 128'(found), 128'(1));
            repeat (j.pre) @(posedge clk);
            @(posedge clk); #1 tpu_busy = 1;
            repeat (j.blen) @(posedge clk);
            #1 tpu_busy = 0;
        end
        w = 0; t = 0;
        while (!done_seen && t < 1000) begin
            m_ready = w >= j.hold;
            @(negedge clk);
            if (m_valid) w = m_ready ? 0 : w + 1;
            @(posedge clk); #1;
            t++;
        end
        m_ready = 0;
        chk("done_seen", 128'(done_seen), 128'(1));
        chk("a_count", 128'(a_cnt), 128'(j.na));
        chk("b_count", 128'(b_cnt), 128'(j.nb));
        chk("row_count", 128'(n_rows), 128'(j.nc));
        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        chk("start_count", 128'(n_start), 128'(j.err ? 0 : 1));
        chk("done_count", 128'(n_done), 128'(1));
        chk("cfg_err", 128'(err_at_done), 128'(j.err));
        chk("exclusive", 128'(excl_err), 128'(0));
        chk("dims_stable", 128'(dims_err), 128'(0));
        if (j.err) chk("err_latency", 128'(done_cyc - acc_cyc), 128'(2));
        else begin
            chk("a_last", 128'(a_last), 128'(j.na - 1));
            chk("b_last", 128'(b_last), 128'(j.nb - 1));
            chk("c_last", 128'(c_last), 128'(j.nc - 1));
            chk("drain_latency", 128'(mv_cyc - start_cyc), 128'(j.pre + j.blen + 4));
        end
    endtask

    initial begin
        jobs[0] = '{8'd4, 8'd4, 8'd4, 1'b0, 0, 2, 10, 4, 4, 4, 1'b0};
        jobs[1] = '{8'd8, 8'd6, 8'd5, 1'b0, 0, 0, 3, 16, 16, 12, 1'b0};
        jobs[2] = '{8'd3, 8'd5, 8'd9, 1'b1, 0, 1, 4, 6, 9, 15, 1'b0};
        jobs[3] = '{8'd2, 8'd3, 8'd4, 1'b0, 5, 0, 2, 2, 2, 3, 1'b0};
        jobs[4] = '{8'd4, 8'd4, 8'd0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b1};
        jobs[5] = '{8'd2, 8'd8, 8'd1, 1'b0, 1, 0, 1, 4, 2, 8, 1'b0};
        jobs[6] = '{8'd4, 8'd4, 8'd4, 1'b0, 2, 3, 5, 4, 4, 4, 1'b0};
        clear_job(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 check_idle_outputs();
        rst_n = 1;
        @(posedge clk); #1;
        chk("rst_cfg_ready", 128'(cfg_ready), 128'(1));
        for (int i = 0; i < 6; i++) run_job(jobs[i]);

        clear_job(0, 8'd1, 8'd0, 8'd3);
        cfg_K = 1; cfg_M = 0; cfg_N = 3; cfg_valid = 1;
        repeat (2) @(posedge clk);
        #1 chk("fin_done", 128'({done, cfg_err}), 128'(3));
        @(posedge clk); #1 cfg_valid = 0;
        chk("fin_ignore", 128'(cfg_ready), 128'(1));
        repeat (3) @(posedge clk);
        #1 chk("fin_once", 128'(n_done), 128'(1));

        clear_job(4, 8'd4, 8'd4, 8'd4);
        start_job(4, 4, 4);
        stream(6, 1'b0);
        rst_n = 0;
        #2 check_idle_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (4) @(posedge clk);
        #1 chk("rst_no_done", 128'(n_done), 128'(0));
        chk("rst_ready", 128'(cfg_ready), 128'(1));
        run_job(jobs[6]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tpu_host_ctrl.md
TPU_HOST_CTRL -- requirements
Module: tpu_host_ctrl

Interface
REQ-001 Clocking SHALL be one clock, clk; reset SHALL be rst_n, asynchronous and active-low.
REQ-002 Parameter: IDX_W, default 16, width of all buffer index ports.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cfg_valid / cfg_ready  in / out  1 / 1  job handshake; cfg_K, cfg_M, cfg_N  in  8 each  job dimensions.
REQ-006 s_valid / s_ready / s_data  in / out / in  1 / 1 / 32  operand stream; A words first, then B words.
REQ-007 A_wr_en, A_index, A_data_in  out  1, IDX_W, 32  A global-buffer write port; B_wr_en, B_index, B_data_in  out  same widths  B write port.
REQ-008 C_index  out  IDX_W  C read address; C_data_out  in  128  C read data, valid one cycle after C_index.
REQ-009 tpu_in_valid  out  1  start pulse; tpu_K, tpu_M, tpu_N  out  8 each  latched dims; tpu_busy  in  1  TPU busy.
REQ-010 m_valid / m_ready / m_data  out / in / out  1 / 1 / 128  result stream; done  out  1  end-of-job pulse; cfg_err  out  1  error flag.

Function
REQ-011 Word counts, fixed at cfg accept: nA = K*ceil(M/4), nB = K*ceil(N/4), nC = M*ceil(N/4); arithmetic SHALL be 16-bit unsigned, no overflow for 8-bit dims.
REQ-012 FSM states SHALL be IDLE, LOAD_A, LOAD_B, START, WAIT_HI, WAIT_LO, DRAIN_RD, DRAIN_CAP, DRAIN_OUT, FINISH.
REQ-013 IDLE: cfg_ready=1; on cfg_valid, latch K/M/N, compute counts, go LOAD_A; cfg_ready=0 in all other states.
REQ-014 Any of K, M, N zero: accept, skip to FINISH, assert cfg_err for the done cycle; no buffer writes, no tpu_in_valid.
REQ-015 LOAD_A: s_ready=1; each s_valid&s_ready beat drives A_wr_en=1, A_index=beat count (0..nA-1), A_data_in=s_data in the same cycle; after beat nA-1 go LOAD_B.
REQ-016 LOAD_B: same as LOAD_A on B port with nB beats, then START; s_ready=0 outside LOAD_A/LOAD_B.
REQ-017 START: tpu_in_valid=1 for exactly one cycle with tpu_K/M/N stable; tpu_K/M/N SHALL remain stable until FINISH.
REQ-018 WAIT_HI: wait for tpu_busy=1, then WAIT_LO; WAIT_LO: wait for tpu_busy=0, then DRAIN_RD with row counter 0.
REQ-019 Busy already 1 in the cycle after START: WAIT_HI SHALL exit after one cycle.
REQ-020 DRAIN_RD drives C_index=row; DRAIN_CAP registers C_data_out into m_data; DRAIN_OUT holds m_valid=1, m_data stable until m_ready.
REQ-021 Row sequencing: on handshake, row<nC-1 -> row+1, DRAIN_RD; otherwise FINISH. Latency: entry to DRAIN_RD -> m_valid is 2 cycles.
REQ-022 FINISH: done=1 for one cycle, then IDLE; cfg_valid during FINISH SHALL be ignored.
REQ-023 A_wr_en, B_wr_en, tpu_in_valid, done SHALL never be asserted simultaneously; C_index SHALL hold its last value outside DRAIN_RD.

Reset
REQ-024 On rst_n low, at any state: FSM->IDLE; counters and latched dims 0; all valid/enable/done/cfg_err outputs 0; indices and data outputs 0; cfg_ready 1 once rst_n is high.
REQ-025 Reset mid-job SHALL abandon the job without a done pulse; partial buffer contents are not restored.

Structure
REQ-026 Shared package tpu_pkg SHALL hold the FSM state enum, IDX_W, the ceil-div-by-4 function, and the buffer word widths (32, 128).
REQ-027 One sub-module is natural: tpu_c_drain (DRAIN_RD/CAP/OUT path plus row counter); everything else stays in tpu_host_ctrl.

Verification
REQ-028 K=4, M=4, N=4, stream 8 words, TPU model busy 1 for 10 cycles -> A indices 0..3, B indices 0..3, one tpu_in_valid, 4 m_data rows equal to model C rows 0..3, done once.
REQ-029 K=8, M=6, N=5 -> nA=16, nB=16, nC=12; last A_index 15, last B_index 15, last C_index 11.
REQ-030 s_valid toggling 1/0 every cycle -> writes only on handshake beats, indices contiguous, no gaps or repeats.
REQ-031 m_ready held low 5 cycles per row -> m_data stable while m_valid=1; each row delivered exactly once.
REQ-032 cfg_N=0 -> no writes, no tpu_in_valid, done with cfg_err=1 two cycles after accept.
REQ-033 rst_n low during LOAD_B, then K=M=N=4 job -> outputs at reset values, new job completes normally with indices restarting at 0.
